regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-read-port integer register file for the RV32 core.
//  Replaces the fixed 32x32 two-read file: clocked write, optional write->read bypass,
//  hardwired-zero register 0, and a reset-time clear sequencer that zeroes every entry.
//  Sits between decode (read addresses) and writeback (write port); ready gates issue.
// PARAMETERS
//  XLEN   32  data width of each register, bits
//  NREGS  32  number of registers; 2..2**AW
//  AW     5   register address width, bits
//  NRD    2   number of read ports, 1..4
// PORTS
//  clk      in   1         clock; all state updates on rising edge
//  rst      in   1         reset, synchronous, active-high
//  wr_en    in   1         write request this cycle
//  wr_addr  in   AW        write register index
//  wr_data  in   XLEN      write data
//  rd_addr  in   NRD*AW    read indices; port k = rd_addr[k*AW +: AW]
//  rd_data  out  NRD*XLEN  read data; port k = rd_data[k*XLEN +: XLEN]; combinational
//  ready    out  1         1 = clear done, file accepts writes and returns stored data
//  wr_drop  out  1         registered 1-cycle pulse: previous cycle's wr_en was discarded
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (rst).
//  - States: CLEAR, READY. rst=1 at an edge: state<=CLEAR, clr_cnt<=0, wr_drop<=0, ready=0.
//  - CLEAR with rst=0: each edge writes mem[clr_cnt]<=0, clr_cnt++. The edge with
//    clr_cnt==NREGS-1 moves to READY. ready rises NREGS edges after rst deasserts.
//  - rst asserted mid-clear restarts the sweep at index 0. No other exit from CLEAR.
//  - READY: ready=1. Stays in READY until rst.
//  - Write: READY, wr_en=1, wr_addr!=0, wr_addr<NREGS -> mem[wr_addr]<=wr_data at edge.
//  - Dropped write: wr_en=1 and any of the following -> no state change, wr_drop=1 next cycle:
//    CLEAR state, wr_addr==0, or wr_addr>=NREGS.
//  - wr_drop is 0 in every other cycle, including while rst=1.
//  - Read, per port, independent: rd_addr==0 or rd_addr>=NREGS -> 0.
//    CLEAR state -> 0 for every address. Otherwise -> mem[rd_addr].
//  - Several ports reading the same address all get the same value.
//  - Bypass: see CONFIGURATION. Bypass never applies to a dropped write.
//  - Storage is not otherwise initialised. Contents before the first complete clear are undefined
//    and never visible, because CLEAR forces reads to 0.
//  - Latency: write visible to reads the cycle after the edge (0 cycles with bypass).
// CONFIGURATION
//  Macro REGFILE_BYPASS_EN.
//  - Defined: any read port whose rd_addr equals an accepted same-cycle write's wr_addr
//    returns wr_data combinationally, i.e. write-before-read, so writeback needs no forward mux.
//  - Undefined: that read port returns the old mem value; the new value appears next cycle.
//  - wr_drop, clear and zero-register rules are identical in both builds.
// TESTING
//  1 Reset/clear: rst=1 2 cycles, release -> ready=0 for 32 edges, 1 after the 32nd.
//    All 32 registers then read 0.
//  2 Write/read: wr x5=0xDEADBEEF -> next cycle rd port0=x5 and port1=x5 both read 0xDEADBEEF.
//    rd x6 reads 0.
//  3 Zero/range: wr x0=0x1234 -> wr_drop=1 next cycle, x0 reads 0.
//    Run with NREGS=16: wr x20=1 -> wr_drop=1, and x20 reads 0.
//  4 Clear-phase write: wr x3=7 on the 10th cycle of CLEAR -> wr_drop=1.
//    x3 reads 0 after ready.
//  5 Mid-clear reset: rst pulse at clear cycle 20 -> ready first rises 32 edges after the second
//    release. All registers then read 0.
//  6 Same-cycle R/W: x7=0x11, then wr x7=0x22 while reading x7.
//    With REGFILE_BYPASS_EN the read returns 0x22; without it, 0x11.
//    Both builds read 0x22 the next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with a reset-time clear sweep and hardwired-zero x0.
// Optional write->read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic                 ready,
  output logic                 wr_drop
);

  localparam int            IW       = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [AW:0]   NREGS_X  = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
  logic                wr_drop_q, wr_drop_d;
  logic [XLEN-1:0]     mem [NREGS];

  logic                wr_in_range;
  logic                wr_acc;
  logic                clr_we;
  logic [AW-1:0]       ra;

  always_comb begin
    wr_in_range = (wr_addr != '0) && ({1'b0, wr_addr} < NREGS_X);
    wr_acc      = wr_en && !rst && (state_q == ST_READY) && wr_in_range;
    clr_we      = !rst && (state_q == ST_CLEAR);

    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    wr_drop_d   = wr_en && !wr_acc;
    if (rst) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
      wr_drop_d = 1'b0;
    end else if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_IDX) begin
        state_d   = ST_READY;
        clr_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_cnt_q <= clr_cnt_d;
    wr_drop_q <= wr_drop_d;
  end

  // Storage: the clear sweep has priority; writes cannot be accepted during CLEAR anyway.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_q[IW-1:0]] <= '0;
    end else if (wr_acc) begin
      mem[wr_addr[IW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    ra      = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      if ((state_q == ST_READY) && (ra != '0) && ({1'b0, ra} < NREGS_X)) begin
        rd_data[k*XLEN +: XLEN] = mem[ra[IW-1:0]];
`ifdef REGFILE_BYPASS_EN
        if (wr_acc && (ra == wr_addr)) begin
          rd_data[k*XLEN +: XLEN] = wr_data;
        end
`endif
      end
    end
  end

  assign ready   = (state_q == ST_READY);
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 32-entry and a 16-entry instance share one stimulus
// stream; a high-level model predicts every cycle's outputs and a monitor compares them.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic        ready_a, ready_b, drop_a, drop_b;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .ready(ready_a), .wr_drop(drop_a)
  );

  regfile_mp #(.XLEN(32), .NREGS(16), .AW(5), .NRD(2)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .ready(ready_b), .wr_drop(drop_b)
  );

  // Reference model: register contents, edges left until the file is usable, pending drop flag.
  int          nreg [2] = '{32, 16};
  logic [31:0] m [2][32];
  int          rem [2];
  logic        drp [2];

  typedef struct packed {
    logic [1:0]       rdy;
    logic [1:0]       drop;
    logic [3:0][31:0] rd;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_pass = 0;
  int   n_tot  = 0;

  function automatic logic [31:0] mread(input int i, input logic [4:0] a, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (rem[i] != 0 || a == 5'd0 || int'(a) >= nreg[i]) return 32'd0;
    if (BYPASS && we && a == wa) return wd;
    return m[i][a];
  endfunction

  task automatic cycle(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a0, input logic [4:0] a1);
    exp_t e;
    logic acc;
    @(posedge clk);
    #1;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = {a1, a0};
    for (int i = 0; i < 2; i++) begin
      e.rdy[i]      = (rem[i] == 0);
      e.drop[i]     = drp[i];
      e.rd[i*2]     = mread(i, a0, we, wa, wd);
      e.rd[i*2 + 1] = mread(i, a1, we, wa, wd);
    end
    q.push_back(e);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        rem[i] = nreg[i];
        drp[i] = 1'b0;
      end else begin
        acc    = we && rem[i] == 0 && wa != 5'd0 && int'(wa) < nreg[i];
        drp[i] = we && !acc;
        if (acc) m[i][wa] = wd;
        if (rem[i] > 0) begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) for (int j = 0; j < 32; j++) m[i][j] = 32'd0;
        end
      end
    end
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("ready_a", {31'd0, ready_a}, {31'd0, me.rdy[0]});
      chk("ready_b", {31'd0, ready_b}, {31'd0, me.rdy[1]});
      chk("wr_drop_a", {31'd0, drop_a}, {31'd0, me.drop[0]});
      chk("wr_drop_b", {31'd0, drop_b}, {31'd0, me.drop[1]});
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("rd_a_port%0d", p), rd_data_a[p*32 +: 32], me.rd[p]);
        chk($sformatf("rd_b_port%0d", p), rd_data_b[p*32 +: 32], me.rd[2 + p]);
      end
    end
  end

  task automatic read_all();
    for (int r = 0; r < 32; r += 2) cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'(r), 5'(r + 1));
  endtask

  task automatic idle_rand(input int n);
    repeat (n) cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
  endtask

  initial begin
    logic        r, we;
    logic [4:0]  wa, a0, a1;
    logic [31:0] wd;
    rst = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0; rd_addr = 10'd0;
    for (int i = 0; i < 2; i++) begin
      rem[i] = nreg[i];
      drp[i] = 1'b0;
    end
    @(posedge clk);

    // Reset then full clear sweep
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle_rand(32);
    read_all();

    // Write / read on both ports, neighbouring register untouched
    cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd6, 5'd5);

    // x0 and out-of-range writes
    cycle(1'b0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 5'd20, 32'd1, 5'd20, 5'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd20, 5'd20);

    // Write during the clear sweep
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle_rand(9);
    cycle(1'b0, 1'b1, 5'd3, 32'd7, 5'd3, 5'd0);
    repeat (30) cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);

    // Reset in the middle of the sweep restarts it
    cycle(1'b0, 1'b1, 5'd9, 32'hA5A5_0009, 5'd0, 5'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle_rand(19);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    idle_rand(33);
    read_all();

    // Same-cycle write and read
    cycle(1'b0, 1'b1, 5'd7, 32'h11, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);

    // Randomised traffic with occasional resets
    repeat (1500) begin
      r  = ($urandom_range(0, 399) == 0);
      we = !r && ($urandom_range(0, 2) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      a0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      cycle(r, we, wa, wd, a0, a1);
    end
    read_all();

    @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
